reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have parameter MAX_MS, default 999, meaning react_time saturation value in ms.
REQ-002 SHALL have parameter DELAY_MIN, default 1000, meaning minimum random pre-start delay in ms.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value; nonzero.
REQ-004 SHALL have ports: clk  in  1  clock; rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: tick_1ms  in  1  one-cycle strobe per millisecond; machine_state  in  3  controller state code.
REQ-006 SHALL have outputs: react_time  out  10  measured ms; sig_start  out  1  delay expired; sig_overflow  out  1  measurement saturated; sig_cleared  out  1  counter clear done; led_go  out  1  go stimulus lamp.

Function
REQ-007 SHALL decode machine_state as IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7.
REQ-008 SHALL register machine_state each cycle (prev_state); "entry" to a state is machine_state == S and prev_state != S.
REQ-009 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clk cycle.
REQ-010 On WAIT entry, SHALL load delay_cnt (12 bits) with DELAY_MIN + lfsr[10:0], giving 1000..3047 ms.
REQ-011 While in WAIT after entry, SHALL decrement delay_cnt on each tick_1ms; the load takes priority over a coincident tick.
REQ-012 When delay_cnt reaches 0 in WAIT, SHALL assert sig_start for exactly one cycle, then hold it low until the next WAIT entry.
REQ-013 On CLR_CNT1 or CLR_CNT2 entry, SHALL clear react_time to 0; SHALL pulse sig_cleared for one cycle on the following cycle if still in that state.
REQ-014 In START, SHALL increment react_time on each tick_1ms while react_time < MAX_MS; there is no increment on the entry cycle.
REQ-015 In START with react_time == MAX_MS, SHALL assert sig_overflow (registered level) and hold react_time at MAX_MS.
REQ-016 SHALL deassert sig_overflow in any state other than START.
REQ-017 In STORAGE, AVERAGE, COMPARE and IDLE, SHALL hold react_time unchanged.
REQ-018 SHALL drive led_go high iff machine_state == START (registered, one-cycle lag).
REQ-019 If machine_state leaves WAIT before expiry, SHALL abandon delay_cnt with no sig_start; the next WAIT entry reloads it.
REQ-020 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-021 On rstn low, SHALL set react_time=0, sig_start=0, sig_overflow=0, sig_cleared=0, led_go=0, delay_cnt=0, prev_state=IDLE, lfsr=LFSR_SEED.
REQ-022 Reset asserted mid-measurement SHALL abort immediately; after release, the block SHALL wait for a fresh WAIT entry before any sig_start.

Configuration
REQ-023 SHALL support macro RT_FIXED_DELAY_EN.
- Defined: WAIT entry loads exactly DELAY_MIN (deterministic, for test); the LFSR still runs.
- Undefined: the random delay per REQ-010 applies.

Structure
REQ-024 State codes (REQ-007) and the MAX_MS/DELAY_MIN defaults SHALL live in shared package rt_pkg, also used by the controller.
REQ-025 The LFSR SHALL be a sub-module rt_lfsr16 (clk, rstn, seed parameter, 16-bit state output).

Verification
REQ-026 RT_FIXED_DELAY_EN defined, ticks every 10 clk, WAIT entered -> sig_start pulses once exactly 1000 ticks later.
REQ-027 CLR_CNT1 entered with react_time=437 -> react_time=0 next cycle; sig_cleared high for one cycle on the cycle after.
REQ-028 START held for 250 ticks, then STORAGE -> react_time=250 and holds 250 through STORAGE and AVERAGE.
REQ-029 START held for 1200 ticks -> react_time stops at 999; sig_overflow high from the cycle react_time becomes 999 until leaving START.
REQ-030 Random mode, 20 WAIT entries -> every delay is within 1000..3047 ticks and at least two values differ.
REQ-031 rstn pulsed low at tick 120 of START -> all outputs 0; no sig_start without a new WAIT entry, even with machine_state held at WAIT across reset.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared state codes and default timing constants for the reaction timer and its controller.
// Latency: none (types, constants and a helper function only).
// Backpressure: none.
package rt_pkg;

    // Controller state codes as driven on machine_state.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_CLR_CNT1 = 3'd2,
        ST_START    = 3'd3,
        ST_STORAGE  = 3'd4,
        ST_CLR_CNT2 = 3'd5,
        ST_AVERAGE  = 3'd6,
        ST_COMPARE  = 3'd7
    } rt_state_e;

    localparam int          RT_MAX_MS    = 999;
    localparam int          RT_DELAY_MIN = 1000;
    localparam logic [15:0] RT_LFSR_SEED = 16'hACE1;

    function automatic logic is_clear_state(input logic [2:0] s);
        return (s == ST_CLR_CNT1) || (s == ST_CLR_CNT2);
    endfunction

endpackage

// File: rtl/rt_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the pre-start delay entropy source.
// Latency: advances once per clk cycle; state is a direct register output.
// Backpressure: none, free-running.
//
// Ports: clk, rstn (async active-low, loads SEED), state[15:0] current LFSR value.
module rt_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [15:0] state
);

    logic feedback;

    // Bit 16 of the polynomial is state[15]; shift toward the MSB.
    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer datapath: random pre-start delay, ms reaction counter, go lamp and status strobes.
// Latency: all outputs registered, one clk after the sampled machine_state / tick_1ms.
// Backpressure: none; tick_1ms and machine_state are sampled every cycle.
//
// Ports: clk, rstn (async active-low); tick_1ms (1 ms strobe); machine_state[2:0] (controller state);
//        react_time[9:0], sig_start, sig_overflow, sig_cleared, led_go (all registered).
// Build option: define RT_FIXED_DELAY_EN to make every WAIT entry load exactly DELAY_MIN.
module reaction_timer
    import rt_pkg::*;
#(
    parameter int          MAX_MS    = RT_MAX_MS,
    parameter int          DELAY_MIN = RT_DELAY_MIN,
    parameter logic [15:0] LFSR_SEED = RT_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1ms,
    input  logic [2:0] machine_state,
    output logic [9:0] react_time,
    output logic       sig_start,
    output logic       sig_overflow,
    output logic       sig_cleared,
    output logic       led_go
);

    localparam logic [9:0]  MAX_V  = 10'(MAX_MS);
    localparam logic [11:0] DMIN_V = 12'(DELAY_MIN);

    logic [2:0]  prev_state;
    logic [15:0] lfsr;
    logic [11:0] delay_cnt;
    logic [11:0] delay_load;
    logic        armed;
    logic        wait_ok;
    logic        clr_pend;
    logic        in_wait;
    logic        in_start;
    logic        state_entry;
    logic        wait_entry;
    logic        clr_entry;
    logic        fire;
    logic        lfsr_unused;
    logic [9:0]  react_next;

    rt_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .state (lfsr)
    );

    assign in_wait     = (machine_state == ST_WAIT);
    assign in_start    = (machine_state == ST_START);
    assign state_entry = (machine_state != prev_state);
    // wait_ok stays low after reset until a non-WAIT state is seen, so a WAIT
    // held across reset is not mistaken for a fresh entry.
    assign wait_entry  = in_wait && state_entry && wait_ok;
    assign clr_entry   = is_clear_state(machine_state) && state_entry;

`ifdef RT_FIXED_DELAY_EN
    assign delay_load  = DMIN_V;
    assign lfsr_unused = ^lfsr;
`else
    assign delay_load  = DMIN_V + {1'b0, lfsr[10:0]};
    assign lfsr_unused = ^lfsr[15:11];
`endif

    // Fire on the tick that takes the count to zero (or immediately if loaded with zero).
    assign fire = armed && in_wait && !state_entry &&
                  ((delay_cnt == 12'd0) || (tick_1ms && (delay_cnt == 12'd1)));

    always_comb begin
        react_next = react_time;
        if (clr_entry) begin
            react_next = '0;
        end else if (in_start && !state_entry && tick_1ms && (react_time < MAX_V)) begin
            react_next = react_time + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_state   <= ST_IDLE;
            delay_cnt    <= '0;
            armed        <= 1'b0;
            wait_ok      <= 1'b0;
            clr_pend     <= 1'b0;
            react_time   <= '0;
            sig_start    <= 1'b0;
            sig_overflow <= 1'b0;
            sig_cleared  <= 1'b0;
            led_go       <= 1'b0;
        end else begin
            prev_state <= machine_state;
            if (!in_wait) begin
                wait_ok <= 1'b1;
            end

            // Load wins over a coincident tick; leaving WAIT abandons the countdown.
            if (wait_entry) begin
                delay_cnt <= delay_load;
                armed     <= 1'b1;
            end else begin
                if (armed && in_wait && tick_1ms && (delay_cnt != 12'd0)) begin
                    delay_cnt <= delay_cnt - 12'd1;
                end
                if (fire || !in_wait) begin
                    armed <= 1'b0;
                end
            end

            sig_start    <= fire;
            react_time   <= react_next;
            sig_overflow <= in_start && (react_next == MAX_V);
            clr_pend     <= clr_entry;
            sig_cleared  <= clr_pend && !state_entry;
            led_go       <= in_start;
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: directed scenarios plus a randomized state walk
// scored against a behavioural model of the counter, clear strobe, overflow flag and lamp.
// Compile with RT_FIXED_DELAY_EN defined to exercise the deterministic delay build.
module tb_reaction_timer;
    import rt_pkg::*;

    localparam int MAXV = 999;
    localparam int DMIN = 1000;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick_1ms;
    logic [2:0] machine_state;
    logic [9:0] react_time;
    logic       sig_start;
    logic       sig_overflow;
    logic       sig_cleared;
    logic       led_go;

    int checks = 0;
    int errors = 0;
    int tick_period = 10;
    int tick_phase = 0;
    int ticks_seen = 0;
    int start_cnt = 0;

    logic [2:0] walk_states [0:6] = '{ST_IDLE, ST_CLR_CNT1, ST_START, ST_STORAGE,
                                       ST_CLR_CNT2, ST_AVERAGE, ST_COMPARE};

    reaction_timer #(
        .MAX_MS    (MAXV),
        .DELAY_MIN (DMIN),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .tick_1ms      (tick_1ms),
        .machine_state (machine_state),
        .react_time    (react_time),
        .sig_start     (sig_start),
        .sig_overflow  (sig_overflow),
        .sig_cleared   (sig_cleared),
        .led_go        (led_go)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // One clock: drive tick per the current period, return at the next negedge.
    task automatic adv();
        tick_1ms = (tick_phase == tick_period - 1);
        tick_phase = (tick_phase >= tick_period - 1) ? 0 : tick_phase + 1;
        @(negedge clk);
        if (tick_1ms) ticks_seen++;
        if (sig_start) start_cnt++;
    endtask

    function automatic bit delay_ok(input int d);
`ifdef RT_FIXED_DELAY_EN
        return d == DMIN;
`else
        return (d >= DMIN) && (d <= DMIN + 2047);
`endif
    endfunction

    // Enter WAIT, count ticks after the entry cycle until sig_start; count pulse cycles.
    task automatic measure_wait(output int delay, output int pulses);
        int t0;
        machine_state = ST_WAIT;
        start_cnt = 0;
        adv();
        t0 = ticks_seen;
        delay = -1;
        for (int i = 0; i < 40000 && delay < 0; i++) begin
            adv();
            if (sig_start) delay = ticks_seen - t0;
        end
        repeat (30) adv();
        pulses = start_cnt;
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic clear_counter();
        machine_state = ST_CLR_CNT2;
        repeat (2) adv();
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic run_start(input int n);
        int t0;
        machine_state = ST_START;
        adv();
        t0 = ticks_seen;
        while (ticks_seen - t0 < n) adv();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({react_time, sig_start, sig_overflow, sig_cleared, led_go} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got rt=%0d st=%b ov=%b cl=%b go=%b want all 0",
                     react_time, sig_start, sig_overflow, sig_cleared, led_go);
        end
        rstn = 1'b1;
        repeat (5) adv();
        checks++;
        if ({react_time, sig_start, sig_overflow, sig_cleared, led_go} !== 14'd0) begin
            errors++;
            $display("FAIL idle_after_reset got rt=%0d st=%b ov=%b cl=%b go=%b want all 0",
                     react_time, sig_start, sig_overflow, sig_cleared, led_go);
        end
    endtask

`ifdef RT_FIXED_DELAY_EN
    task automatic test_fixed_delay();
        int d, p;
        tick_period = 10;
        tick_phase = $urandom_range(0, 9);
        measure_wait(d, p);
        checks++;
        if (d != DMIN) begin
            errors++;
            $display("FAIL fixed_delay got %0d ticks want %0d", d, DMIN);
        end
        checks++;
        if (p != 1) begin
            errors++;
            $display("FAIL fixed_delay_pulse got %0d high cycles want 1", p);
        end
    endtask
`else
    task automatic test_random_delay();
        int d, p, dmin_seen, dmax_seen;
        tick_period = 1;
        dmin_seen = 1 << 30;
        dmax_seen = -1;
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 20)) adv();
            measure_wait(d, p);
            checks++;
            if (!delay_ok(d)) begin
                errors++;
                $display("FAIL random_delay[%0d] got %0d ticks want 1000..3047", k, d);
            end
            checks++;
            if (p != 1) begin
                errors++;
                $display("FAIL random_delay_pulse[%0d] got %0d high cycles want 1", k, p);
            end
            if (d < dmin_seen) dmin_seen = d;
            if (d > dmax_seen) dmax_seen = d;
        end
        checks++;
        if (dmin_seen == dmax_seen) begin
            errors++;
            $display("FAIL random_delay_spread got all delays %0d want at least two distinct", dmin_seen);
        end
    endtask
`endif

    task automatic test_clear();
        tick_period = 1;
        clear_counter();
        run_start(437);
        checks++;
        if (react_time !== 10'd437) begin
            errors++;
            $display("FAIL clear_preload got rt=%0d want 437", react_time);
        end
        machine_state = ST_STORAGE;
        adv();
        machine_state = ST_CLR_CNT1;
        adv();
        checks++;
        if (react_time !== 10'd0 || sig_cleared !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry got rt=%0d cl=%b want rt=0 cl=0", react_time, sig_cleared);
        end
        adv();
        checks++;
        if (sig_cleared !== 1'b1) begin
            errors++;
            $display("FAIL clear_strobe got cl=%b want 1", sig_cleared);
        end
        adv();
        checks++;
        if (sig_cleared !== 1'b0) begin
            errors++;
            $display("FAIL clear_strobe_end got cl=%b want 0", sig_cleared);
        end
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic test_start_hold();
        int bad;
        tick_period = 10;
        tick_phase = $urandom_range(0, 9);
        clear_counter();
        run_start(250);
        checks++;
        if (react_time !== 10'd250 || led_go !== 1'b1) begin
            errors++;
            $display("FAIL start_250 got rt=%0d go=%b want rt=250 go=1", react_time, led_go);
        end
        bad = 0;
        machine_state = ST_STORAGE;
        repeat (40) begin
            adv();
            if (react_time !== 10'd250 || led_go !== 1'b0) bad++;
        end
        machine_state = ST_AVERAGE;
        repeat (40) begin
            adv();
            if (react_time !== 10'd250 || led_go !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL start_hold got %0d bad cycles (last rt=%0d go=%b) want rt=250 go=0",
                     bad, react_time, led_go);
        end
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic test_overflow();
        int t0, n, exp_rt, bad;
        tick_period = 1;
        clear_counter();
        machine_state = ST_START;
        adv();
        t0 = ticks_seen;
        checks++;
        if (react_time !== 10'd0 || sig_overflow !== 1'b0) begin
            errors++;
            $display("FAIL start_entry_no_inc got rt=%0d ov=%b want rt=0 ov=0", react_time, sig_overflow);
        end
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            adv();
            n = ticks_seen - t0;
            exp_rt = (n < MAXV) ? n : MAXV;
            if (react_time !== exp_rt[9:0] || sig_overflow !== (exp_rt == MAXV)) begin
                if (bad == 0)
                    $display("FAIL overflow_step tick %0d got rt=%0d ov=%b want rt=%0d ov=%b",
                             n, react_time, sig_overflow, exp_rt, exp_rt == MAXV);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL overflow_run got %0d bad cycles want 0", bad);
        end
        machine_state = ST_STORAGE;
        adv();
        checks++;
        if (react_time !== 10'd999 || sig_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_leave got rt=%0d ov=%b want rt=999 ov=0", react_time, sig_overflow);
        end
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic test_abandon();
        int d, p;
        tick_period = 1;
        start_cnt = 0;
        machine_state = ST_WAIT;
        repeat (501) adv();
        machine_state = ST_IDLE;
        repeat (3100) adv();
        checks++;
        if (start_cnt != 0) begin
            errors++;
            $display("FAIL abandon_no_start got %0d start cycles want 0", start_cnt);
        end
        measure_wait(d, p);
        checks++;
        if (!delay_ok(d) || p != 1) begin
            errors++;
            $display("FAIL abandon_reload got delay=%0d pulses=%0d want valid delay and 1 pulse", d, p);
        end
    endtask

    task automatic test_random_walk();
        int m_rt, hold, bad_rt, bad_flags, i;
        logic [2:0] m_prev;
        bit m_pend, entry, clr, tk, e_cl, e_ov, e_go;
        tick_period = 1;
        clear_counter();
        m_rt = 0;
        m_prev = ST_IDLE;
        m_pend = 1'b0;
        bad_rt = 0;
        bad_flags = 0;
        i = 0;
        while (i < 600) begin
            machine_state = walk_states[$urandom_range(0, 6)];
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                tk = ($urandom_range(0, 1) == 1);
                tick_1ms = tk;
                @(negedge clk);
                entry = (machine_state != m_prev);
                clr = (machine_state == ST_CLR_CNT1) || (machine_state == ST_CLR_CNT2);
                if (clr && entry) m_rt = 0;
                else if (machine_state == ST_START && !entry && tk && m_rt < MAXV) m_rt++;
                e_cl = m_pend && !entry;
                m_pend = clr && entry;
                e_ov = (machine_state == ST_START) && (m_rt == MAXV);
                e_go = (machine_state == ST_START);
                m_prev = machine_state;
                if (react_time !== m_rt[9:0]) begin
                    if (bad_rt == 0)
                        $display("FAIL walk_rt step %0d got %0d want %0d", i, react_time, m_rt);
                    bad_rt++;
                end
                if ({sig_start, sig_overflow, sig_cleared, led_go} !== {1'b0, e_ov, e_cl, e_go}) begin
                    if (bad_flags == 0)
                        $display("FAIL walk_flags step %0d got st/ov/cl/go=%b%b%b%b want 0%b%b%b",
                                 i, sig_start, sig_overflow, sig_cleared, led_go, e_ov, e_cl, e_go);
                    bad_flags++;
                end
                i++;
            end
        end
        checks++;
        if (bad_rt != 0) begin
            errors++;
            $display("FAIL walk_react_time got %0d bad steps want 0", bad_rt);
        end
        checks++;
        if (bad_flags != 0) begin
            errors++;
            $display("FAIL walk_flags_total got %0d bad steps want 0", bad_flags);
        end
        machine_state = ST_IDLE;
        adv();
    endtask

    task automatic test_reset_mid();
        int d, p;
        tick_period = 1;
        clear_counter();
        run_start(120);
        rstn = 1'b0;
        machine_state = ST_WAIT;
        #1;
        checks++;
        if ({react_time, sig_start, sig_overflow, sig_cleared, led_go} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got rt=%0d st=%b ov=%b cl=%b go=%b want all 0",
                     react_time, sig_start, sig_overflow, sig_cleared, led_go);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        start_cnt = 0;
        repeat (3100) adv();
        checks++;
        if (start_cnt != 0 || react_time !== 10'd0) begin
            errors++;
            $display("FAIL reset_held_wait got starts=%0d rt=%0d want starts=0 rt=0", start_cnt, react_time);
        end
        machine_state = ST_IDLE;
        repeat (3) adv();
        measure_wait(d, p);
        checks++;
        if (!delay_ok(d) || p != 1) begin
            errors++;
            $display("FAIL reset_fresh_wait got delay=%0d pulses=%0d want valid delay and 1 pulse", d, p);
        end
    endtask

    initial begin
        rstn = 1'b0;
        tick_1ms = 1'b0;
        machine_state = ST_IDLE;
        test_reset();
`ifdef RT_FIXED_DELAY_EN
        test_fixed_delay();
`else
        test_random_delay();
`endif
        test_clear();
        test_start_hold();
        test_overflow();
        test_abandon();
        test_random_walk();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
